// File: rtl/pwm_capture_if.sv
// Bundles the PWM measurement signals: the sampled input and the reported results.
interface pwm_capture_if #(
    parameter int N = 32
);
    logic         pwm_in;
    logic [N-1:0] period_out;
    logic [N-1:0] high_out;
    logic         valid;
    logic         idle;
    logic         level;

    modport master (
        output pwm_in,
        input  period_out, high_out, valid, idle, level
    );

    modport slave (
        input  pwm_in,
        output period_out, high_out, valid, idle, level
    );
endinterface

// File: rtl/pwm_capture.sv
// Measures period (rise to rise) and high time of an asynchronous PWM input in clk cycles,
// with a timeout that drops back to idle and reports the static input level.
//
// state | meaning
// IDLE  | no measurement armed; level follows the synchronised input
// RUN   | armed by a rise; each further rise reports period/high with valid
module pwm_capture #(
    parameter int          N       = 32,
    parameter int unsigned TIMEOUT = 100_000_000
) (
    input logic          clk,
    input logic          rst_n,
    pwm_capture_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [N-1:0] TO_M1  = N'(TIMEOUT - 1);
    localparam logic [N-1:0] TO_VAL = N'(TIMEOUT);

    state_t       state;
    logic         s1, s, s_d;
    logic         rise;
    logic [N-1:0] per_cnt;
    logic [N-1:0] hi_cnt;
    logic [N-1:0] period_q;
    logic [N-1:0] high_q;
    logic         valid_q;
    logic         idle_q;
    logic         level_q;

    assign rise = s & ~s_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= 1'b0;
            s       <= 1'b0;
            s_d     <= 1'b0;
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else begin
            s1  <= bus.pwm_in;
            s   <= s1;
            s_d <= s;
            if (rise)
                per_cnt <= '0;
            else if (per_cnt < TO_M1)
                per_cnt <= per_cnt + 1'b1;
            // hi_cnt saturates so a stuck-high input cannot wrap it
            if (rise)
                hi_cnt <= N'(1);
            else if (s && (hi_cnt < TO_VAL))
                hi_cnt <= hi_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            idle_q   <= 1'b1;
            level_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state   <= RUN;
                        idle_q  <= 1'b0;
                        level_q <= 1'b0;
                    end else begin
                        level_q <= s;
                    end
                end
                RUN: begin
                    // a rise on the timeout cycle still counts as a full TIMEOUT period
                    if (rise) begin
                        period_q <= per_cnt + 1'b1;
                        high_q   <= hi_cnt;
                        valid_q  <= 1'b1;
                    end else if (per_cnt == TO_M1) begin
                        state    <= IDLE;
                        period_q <= '0;
                        high_q   <= '0;
                        idle_q   <= 1'b1;
                        level_q  <= s;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.period_out = period_q;
    assign bus.high_out   = high_q;
    assign bus.valid      = valid_q;
    assign bus.idle       = idle_q;
    assign bus.level      = level_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with TIMEOUT = 1000; PWM periods are scaled down by ten.
module tb_pwm_capture;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   vcnt = 0;
    int   b2b = 0;
    int   idle_cnt = 0;
    logic prev_v = 1'b0;
    logic [31:0] last_p = '0;
    logic [31:0] last_h = '0;
    int   v0;

    pwm_capture_if #(.N(32)) pif ();

    pwm_capture #(.N(32), .TIMEOUT(1000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (pif)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (pif.valid) begin
            vcnt   = vcnt + 1;
            last_p = pif.period_out;
            last_h = pif.high_out;
            if (prev_v) b2b = b2b + 1;
        end
        if (pif.idle) idle_cnt = idle_cnt + 1;
        prev_v = pif.valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; pwm_in is high for h sampling edges out of p.
    task automatic pwm_cyc(input int p, input int h);
        pif.pwm_in = 1'b1;
        repeat (h) @(posedge clk);
        #1 pif.pwm_in = 1'b0;
        repeat (p - h) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        pif.pwm_in = 1'b0;
        #15;
        check("rst_period", pif.period_out, 0);
        check("rst_high", pif.high_out, 0);
        check("rst_valid", pif.valid, 0);
        check("rst_idle", pif.idle, 1);
        check("rst_level", pif.level, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // steady PWM
        v0 = vcnt;
        pwm_cyc(600, 150);
        check("first_rise_no_valid", vcnt, v0);
        check("armed_idle", pif.idle, 0);
        repeat (3) pwm_cyc(600, 150);
        check("steady_count", vcnt, v0 + 3);
        check("steady_period", last_p, 600);
        check("steady_high", last_h, 150);
        check("steady_idle", pif.idle, 0);

        // valid latency: registered two edges after the first sampling edge of the rise
        pif.pwm_in = 1'b1;
        @(posedge clk); #1;
        check("lat_k", pif.valid, 0);
        @(posedge clk); #1;
        check("lat_k1", pif.valid, 0);
        @(posedge clk); #1;
        check("lat_k2_valid", pif.valid, 1);
        check("lat_k2_period", pif.period_out, 600);
        check("lat_k2_high", pif.high_out, 150);
        @(posedge clk); #1;
        check("lat_one_cycle", pif.valid, 0);
        repeat (146) @(posedge clk);
        #1 pif.pwm_in = 1'b0;
        repeat (450) @(posedge clk);
        #1;

        // stall high
        v0 = vcnt;
        pif.pwm_in = 1'b1;
        repeat (1002) @(posedge clk); #1;
        check("stall_pre_idle", pif.idle, 0);
        @(posedge clk); #1;
        check("stall_idle", pif.idle, 1);
        check("stall_level", pif.level, 1);
        check("stall_period", pif.period_out, 0);
        check("stall_high", pif.high_out, 0);
        check("stall_valids", vcnt, v0 + 1);

        // resume
        pif.pwm_in = 1'b0;
        repeat (100) @(posedge clk); #1;
        check("idle_level_low", pif.level, 0);
        check("idle_still", pif.idle, 1);
        v0 = vcnt;
        pwm_cyc(600, 150);
        check("resume_rearm", vcnt, v0);
        check("resume_idle", pif.idle, 0);
        pwm_cyc(600, 150);
        check("resume_count", vcnt, v0 + 1);
        check("resume_period", last_p, 600);
        check("resume_high", last_h, 150);

        // boundary period = TIMEOUT
        v0 = vcnt;
        idle_cnt = 0;
        repeat (5) pwm_cyc(1000, 1);
        check("bound_count", vcnt, v0 + 5);
        check("bound_period", last_p, 1000);
        check("bound_high", last_h, 1);
        check("bound_no_idle", idle_cnt, 0);

        // reset mid-period
        pwm_cyc(600, 150);
        pif.pwm_in = 1'b1;
        repeat (150) @(posedge clk);
        #1 pif.pwm_in = 1'b0;
        repeat (150) @(posedge clk);
        #5;
        check("pre_rst_period", pif.period_out, 600);
        check("pre_rst_idle", pif.idle, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_period", pif.period_out, 0);
        check("mid_rst_high", pif.high_out, 0);
        check("mid_rst_valid", pif.valid, 0);
        check("mid_rst_idle", pif.idle, 1);
        check("mid_rst_level", pif.level, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        v0 = vcnt;
        pwm_cyc(600, 150);
        check("post_rst_rearm", vcnt, v0);
        pwm_cyc(600, 150);
        check("post_rst_count", vcnt, v0 + 1);
        check("post_rst_period", last_p, 600);
        check("post_rst_high", last_h, 150);

        // waveform change at a rising edge
        pwm_cyc(600, 300);
        pwm_cyc(600, 300);
        check("old_wave_high", last_h, 300);
        v0 = vcnt;
        pwm_cyc(300, 10);
        check("trans_count", vcnt, v0 + 1);
        check("trans_period", last_p, 600);
        check("trans_high", last_h, 300);
        repeat (2) pwm_cyc(300, 10);
        check("new_count", vcnt, v0 + 3);
        check("new_period", last_p, 300);
        check("new_high", last_h, 10);
        check("no_back_to_back", b2b, 0);

        // duty 0 then full: a single rise arms, then the timeout returns to idle
        rst_n = 1'b0;
        #7;
        rst_n = 1'b1;
        @(posedge clk); #1;
        v0 = vcnt;
        repeat (50) @(posedge clk); #1;
        check("duty0_idle", pif.idle, 1);
        check("duty0_level", pif.level, 0);
        pif.pwm_in = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("full_k1_idle", pif.idle, 1);
        check("full_k1_level", pif.level, 0);
        @(posedge clk); #1;
        check("full_armed", pif.idle, 0);
        repeat (999) @(posedge clk); #1;
        check("full_pre_timeout", pif.idle, 0);
        @(posedge clk); #1;
        check("full_idle", pif.idle, 1);
        check("full_level", pif.level, 1);
        pif.pwm_in = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("drop_k1_level", pif.level, 1);
        @(posedge clk); #1;
        check("drop_k2_level", pif.level, 0);
        check("drop_idle", pif.idle, 1);
        check("duty_no_valid", vcnt, v0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
